// File: rtl/uart_frame_dispatcher_pkg.sv
// Shared constants for the UART frame dispatcher: module count, commit id,
// default pulse/guard/timeout lengths, FSM state encodings and a counter
// width helper.
package uart_frame_dispatcher_pkg;

  localparam int         NUM_OF_MODULES     = 9;
  localparam logic [3:0] DISPATCH_COMMIT_ID = 4'hF;
  localparam int         SHOOT_CYCLES_DEF   = 24;
  localparam int         GUARD_CYCLES_DEF   = 48;
  localparam int         TIMEOUT_CYCLES_DEF = 48000;

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_GUARD   = 3'd3;
  localparam logic [2:0] ST_SHOOT   = 3'd4;

  typedef enum logic [2:0] {
    COLLECT = ST_COLLECT,
    START   = ST_START,
    DRAIN   = ST_DRAIN,
    GUARD   = ST_GUARD,
    SHOOT   = ST_SHOOT
  } state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_frame_dispatcher_pulse_counter.sv
// Loadable down-counter. done is high while the count sits at zero, so a
// value of N-1 loaded on state entry yields a state that lasts N cycles.
module pulse_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/uart_frame_dispatcher.sv
// Collects per-module switch bytes, launches all loaded UARTs together on a
// commit word, waits for them to drain, then fires the global shoot pulse
// after a guard delay.
// Optional: define DISPATCH_TIMEOUT_EN to bound the START/DRAIN wait and add
// the sticky timeout_err output.
module uart_frame_dispatcher
  import uart_frame_dispatcher_pkg::*;
#(
  parameter int NUM_MODULES    = NUM_OF_MODULES,
  parameter int SHOOT_CYCLES   = SHOOT_CYCLES_DEF,
  parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_valid,
  input  logic [11:0]              sin_index,
  input  logic [3:0]               uart_id,
  input  logic [NUM_MODULES-1:0]   tx_busy,
  output logic [NUM_MODULES-1:0]   start_tx,
  output logic [8*NUM_MODULES-1:0] data_to_tx,
  output logic                     shoot,
  output logic                     busy,
  output logic                     overrun
`ifdef DISPATCH_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  // Guard and shoot never overlap, so one counter serves both.
  localparam int GS_MAX = (SHOOT_CYCLES > GUARD_CYCLES) ? SHOOT_CYCLES : GUARD_CYCLES;
  localparam int GS_W   = cnt_width(GS_MAX);
  localparam logic [GS_W-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? GS_W'(GUARD_CYCLES - 1) : '0;
  localparam logic [GS_W-1:0] SHOOT_LOAD = GS_W'(SHOOT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [NUM_MODULES-1:0] loaded_q;
  logic [NUM_MODULES-1:0] start_q;
  logic [7:0]             bytes_q [NUM_MODULES];
  logic                   commit, clear_frame, abort;
  logic                   gs_load, gs_done;
  logic [GS_W-1:0]        gs_val;
  logic                   to_done;
  logic [3:0]             unused_sin_hi;

  assign unused_sin_hi = sin_index[11:8];
  assign start_tx      = start_q;

  pulse_counter #(.W(GS_W)) u_guard_shoot (
    .clk      (clk),
    .reset    (reset),
    .load     (gs_load),
    .en       ((state_q == GUARD) || (state_q == SHOOT)),
    .load_val (gs_val),
    .done     (gs_done)
  );

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  pulse_counter #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (commit),
    .en       ((state_q == START) || (state_q == DRAIN)),
    .load_val (TO_LOAD),
    .done     (to_done)
  );

  // Sticky record of any frame abandoned for lack of TX completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else if (abort) begin
      timeout_err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_done = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter loads and status outputs.
  always_comb begin
    state_d     = state_q;
    commit      = 1'b0;
    clear_frame = 1'b0;
    abort       = 1'b0;
    gs_load     = 1'b0;
    gs_val      = '0;
    shoot       = 1'b0;
    busy        = 1'b1;
    case (state_q)
      COLLECT: begin
        busy = 1'b0;
        if (data_valid && (uart_id == DISPATCH_COMMIT_ID) && (loaded_q != '0)) begin
          commit  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        // Every outstanding request is acknowledged at this edge.
        if ((start_q & ~tx_busy) == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((tx_busy & loaded_q) == '0) begin
          state_d = GUARD;
          gs_load = 1'b1;
          gs_val  = GUARD_LOAD;
        end
      end
      GUARD: begin
        if (gs_done) begin
          state_d = SHOOT;
          gs_load = 1'b1;
          gs_val  = SHOOT_LOAD;
        end
      end
      SHOOT: begin
        shoot = 1'b1;
        if (gs_done) begin
          state_d     = COLLECT;
          clear_frame = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (((state_q == START) || (state_q == DRAIN)) && to_done) begin
      state_d = COLLECT;
      abort   = 1'b1;
      gs_load = 1'b0;
    end
  end

  // Byte capture, loaded mask, per-UART start requests and overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaded_q <= '0;
      start_q  <= '0;
      overrun  <= 1'b0;
      for (int i = 0; i < NUM_MODULES; i++) begin
        bytes_q[i] <= '0;
      end
    end else begin
      if (data_valid && (state_q != COLLECT)) begin
        overrun <= 1'b1;
      end
      if (data_valid && (state_q == COLLECT)) begin
        for (int i = 0; i < NUM_MODULES; i++) begin
          if (uart_id == 4'(i)) begin
            bytes_q[i]  <= sin_index[7:0];
            loaded_q[i] <= 1'b1;
          end
        end
      end
      if (commit) begin
        start_q <= loaded_q;
      end else begin
        start_q <= start_q & ~tx_busy;
      end
      if (clear_frame || abort) begin
        loaded_q <= '0;
      end
      if (abort) begin
        start_q <= '0;
      end
    end
  end

  // Flatten the byte registers onto the TX data bus.
  always_comb begin
    data_to_tx = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      data_to_tx[8*i +: 8] = bytes_q[i];
    end
  end

endmodule
